// File: rtl/game_pkg.sv
// Shared definitions for the tile-game blocks: input FSM states and
// default sizing constants.
package game_pkg;

  localparam int DEF_NUM_TILES      = 4;
  localparam int DEF_MAX_LEN        = 9;
  localparam int DEF_TIMEOUT_CYCLES = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/key_sync_edge.sv
// Push-button front end: 2-flop synchronizer on the active-low keys, a
// single-key press detector and an all-released flag. A press is a key
// going high-to-low while every other key reads high, so chords never
// produce an event.
module key_sync_edge
  import game_pkg::*;
#(
  parameter  int NUM_TILES = DEF_NUM_TILES,
  localparam int TILE_W    = $clog2(NUM_TILES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_TILES-1:0] key,
  output logic                 press,
  output logic [TILE_W-1:0]    press_tile,
  output logic                 all_rel
);

  logic [NUM_TILES-1:0] sync1, sync2, prev;
  logic [NUM_TILES-1:0] ev;
  logic [NUM_TILES-1:0] others;

  // Synchronize the keys and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Falling edge on exactly one key while all others are released.
  always_comb begin
    ev         = '0;
    others     = sync2;
    press_tile = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      others    = sync2;
      others[i] = 1'b1;
      ev[i]     = prev[i] & ~sync2[i] & (&others);
      if (ev[i]) press_tile = TILE_W'(i);
    end
  end

  assign press   = |ev;
  assign all_rel = &sync2;

endmodule

// File: rtl/player_input_ctrl.sv
// Player input controller: latches a target tile sequence on start, then
// checks each single-key press against the current step, pulsing
// match/mismatch/round_done. A key must be fully released before the next
// press counts.
// Optional build macro PLAYER_TIMEOUT_EN adds an idle-input timeout that
// aborts the round after TIMEOUT_CYCLES cycles without a press.
module player_input_ctrl
  import game_pkg::*;
#(
  parameter  int NUM_TILES      = DEF_NUM_TILES,
  parameter  int MAX_LEN        = DEF_MAX_LEN,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int TILE_W         = $clog2(NUM_TILES),
  localparam int CNT_W          = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_TILES-1:0]      KEY,
  input  logic [MAX_LEN*TILE_W-1:0] seq,
  input  logic [CNT_W-1:0]          round_len,
  input  logic                      start,
  output logic                      busy,
  output logic                      tile_valid,
  output logic [TILE_W-1:0]         tile_sel,
  output logic [CNT_W-1:0]          step_idx,
  output logic                      match,
  output logic                      mismatch,
  output logic                      round_done,
  output logic                      timeout
);

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  state_t                    st;
  logic [MAX_LEN*TILE_W-1:0] seq_q;
  logic [CNT_W-1:0]          len_q;
  logic                      press;
  logic [TILE_W-1:0]         press_tile;
  logic                      all_rel;
  logic [TILE_W-1:0]         exp_tile;
  logic                      start_ok;
  logic                      last_step;
  logic                      in_wait;
  logic                      to_hit;

  key_sync_edge #(.NUM_TILES(NUM_TILES)) u_keys (
    .clk        (clk),
    .reset      (reset),
    .key        (KEY),
    .press      (press),
    .press_tile (press_tile),
    .all_rel    (all_rel)
  );

  assign start_ok  = (st == ST_IDLE) && start &&
                     (round_len != '0) && (round_len <= MAX_LEN_C);
  assign last_step = (step_idx == len_q - CNT_W'(1));
  assign in_wait   = (st == ST_WAIT_PRESS) || (st == ST_WAIT_RELEASE);

  // Select the latched target tile for the current step.
  always_comb begin
    exp_tile = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (step_idx == CNT_W'(i)) exp_tile = seq_q[i*TILE_W +: TILE_W];
  end

`ifdef PLAYER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // A press in the same cycle as expiry wins, since it restarts the count.
  assign to_hit = in_wait && !press && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-input counter: restarts on start and on every press event.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (start_ok || press || !in_wait || to_hit) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Round FSM: start, check each press, wait for release between presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      busy       <= 1'b0;
      tile_valid <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      round_done <= 1'b0;
      tile_sel   <= '0;
      step_idx   <= '0;
      seq_q      <= '0;
      len_q      <= '0;
    end else begin
      tile_valid <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      round_done <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (start_ok) begin
            seq_q    <= seq;
            len_q    <= round_len;
            step_idx <= '0;
            busy     <= 1'b1;
            st       <= ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (press) begin
            tile_valid <= 1'b1;
            tile_sel   <= press_tile;
            if (press_tile == exp_tile) begin
              match <= 1'b1;
              if (last_step) begin
                round_done <= 1'b1;
                busy       <= 1'b0;
                st         <= ST_IDLE;
              end else begin
                step_idx <= step_idx + CNT_W'(1);
                st       <= ST_WAIT_RELEASE;
              end
            end else begin
              mismatch <= 1'b1;
              busy     <= 1'b0;
              st       <= ST_IDLE;
            end
          end else if (to_hit) begin
            busy <= 1'b0;
            st   <= ST_IDLE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (to_hit) begin
            busy <= 1'b0;
            st   <= ST_IDLE;
          end else if (all_rel) begin
            st <= ST_WAIT_PRESS;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
